// File: rtl/cnn_job_ctrl.sv
// -----------------------------------------------------------------------------
// cnn_job_ctrl
//
// Job controller that sits between a pixel stream and a CNN core. It collects
// one full image of IMG_SIZE pixels into a local buffer, then holds the image
// steady while it asks the core to run. It waits for the core to finish or
// for a timeout, and presents the outcome on a valid/ready result port.
//
// Ports
//   clk          single clock, everything changes on its rising edge
//   rst          synchronous active-high reset, abandons any job in flight
//   s_valid      pixel stream valid
//   s_ready      pixel stream ready (high only while loading)
//   s_data       pixel value, DATA_W bits
//   img_flat     image buffer to the core, pixel i at [i*DATA_W +: DATA_W]
//   core_enable  run request to the core, a level held for the whole run
//   core_done    core completion, only looked at while running
//   core_value   core prediction, captured when core_done is seen
//   m_valid      result valid
//   m_ready      result ready
//   m_data       result value (0 on timeout)
//   m_err        result is a timeout rather than a prediction
//   busy         high whenever the controller is not loading pixels
// -----------------------------------------------------------------------------
module cnn_job_ctrl #(
  parameter int IMG_SIZE = 64,
  parameter int DATA_W   = 32,
  parameter int OUT_W    = 32,
  parameter int TIMEOUT  = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic [IMG_SIZE*DATA_W-1:0] img_flat,
  output logic                       core_enable,
  input  logic                       core_done,
  input  logic [OUT_W-1:0]           core_value,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUT_W-1:0]           m_data,
  output logic                       m_err,
  output logic                       busy
);

  localparam int PW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [PW-1:0]     pix_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic [DATA_W-1:0] img_buf [IMG_SIZE];
  logic [OUT_W-1:0]  m_data_q;
  logic              m_err_q;

  logic accept;
  logic last_pix;
  logic timed_out;
  logic handoff;

  assign accept    = s_valid && s_ready;
  assign last_pix  = (pix_cnt == PW'(IMG_SIZE - 1));
  assign timed_out = (tmo_cnt == TW'(TIMEOUT - 1));
  assign handoff   = m_valid && m_ready;

  assign m_data = m_data_q;
  assign m_err  = m_err_q;

  // The state register. Reset always lands in LOAD, so that whatever job was
  // in progress is dropped and no result can leak out afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and the handshake outputs. Every output is a pure decode of
  // the current state, so s_ready, core_enable, m_valid and busy can never
  // disagree with one another. In RUN the core's done flag is tested before
  // the timeout, so a completion that lands on the very last allowed cycle
  // still counts as a real prediction.
  always_comb begin
    state_d     = state_q;
    s_ready     = 1'b0;
    core_enable = 1'b0;
    m_valid     = 1'b0;
    busy        = 1'b1;
    case (state_q)
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (accept && last_pix) begin
          state_d = RUN;
        end
      end
      RUN: begin
        core_enable = 1'b1;
        if (core_done || timed_out) begin
          state_d = RESULT;
        end
      end
      RESULT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Pixel index and run-time counter. The pixel index wraps back to zero on
  // the last pixel of an image, so it already reads zero by the time the job
  // returns to LOAD. The timeout counter only moves while the core is
  // running and is cleared when the result is handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (accept) begin
        pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
      end
      if (state_q == RUN && !core_done && !timed_out) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else if (state_q == RESULT && handoff) begin
        tmo_cnt <= '0;
      end
    end
  end

  // Result capture. A real completion stores the core's prediction, and a
  // timeout stores zero with the error flag set. The registers are written
  // only while in RUN, so the result stays frozen for the whole RESULT wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data_q <= '0;
      m_err_q  <= 1'b0;
    end else if (state_q == RUN) begin
      if (core_done) begin
        m_data_q <= core_value;
        m_err_q  <= 1'b0;
      end else if (timed_out) begin
        m_data_q <= '0;
        m_err_q  <= 1'b1;
      end
    end
  end

  // Image buffer. It is written only on an accepted pixel, and pixels are
  // only accepted in LOAD, so the core sees a frozen image for the whole
  // run. Reset wipes every entry so that a partially loaded image can never
  // show through into the next job.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IMG_SIZE; i++) begin
        img_buf[i] <= '0;
      end
    end else if (accept) begin
      img_buf[pix_cnt] <= s_data;
    end
  end

  // Flatten the buffer onto the wide bus the core expects.
  for (genvar g = 0; g < IMG_SIZE; g++) begin : g_flat
    assign img_flat[g*DATA_W +: DATA_W] = img_buf[g];
  end

endmodule

// File: doc/cnn_job_ctrl.md
CNN_JOB_CTRL -- requirements
Module: cnn_job_ctrl

Interface
REQ-001 SHALL have parameter IMG_SIZE, default 64, pixels per image.
REQ-002 SHALL have parameter DATA_W, default 32, pixel width in bits.
REQ-003 SHALL have parameter OUT_W, default 32, CNN result width in bits.
REQ-004 SHALL have parameter TIMEOUT, default 4096, maximum cycles spent in RUN waiting for core_done.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port s_valid  input  1  pixel stream valid.
REQ-008 SHALL have port s_ready  output  1  pixel stream ready.
REQ-009 SHALL have port s_data  input  DATA_W  pixel value.
REQ-010 SHALL have port img_flat  output  IMG_SIZE*DATA_W  image buffer to CNN core; pixel i occupies bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port core_enable  output  1  run request to CNN core.
REQ-012 SHALL have port core_done  input  1  CNN core completion.
REQ-013 SHALL have port core_value  input  OUT_W  CNN core prediction.
REQ-014 SHALL have port m_valid  output  1  result valid.
REQ-015 SHALL have port m_ready  input  1  result ready.
REQ-016 SHALL have port m_data  output  OUT_W  result value.
REQ-017 SHALL have port m_err  output  1  result is a timeout, not a prediction.
REQ-018 SHALL have port busy  output  1  high whenever state is not LOAD.

Function
REQ-019 SHALL implement three states: LOAD, RUN, RESULT.
REQ-020 In LOAD, s_ready SHALL be 1; in RUN and RESULT, s_ready SHALL be 0.
REQ-021 Each cycle with s_valid=1 and s_ready=1 SHALL write s_data to buffer index pix_cnt and increment pix_cnt (0..IMG_SIZE-1).
REQ-022 On the accept at pix_cnt=IMG_SIZE-1, pix_cnt SHALL wrap to 0 and state SHALL go LOAD->RUN, with core_enable=1 in the following cycle.
REQ-023 img_flat SHALL reflect buffer registers continuously; buffer contents SHALL hold unchanged during RUN and RESULT.
REQ-024 In RUN, core_enable SHALL be 1 (level) and a timeout counter SHALL increment from 0 each cycle.
REQ-025 A RUN cycle sampling core_done=1 SHALL capture core_value into m_data, clear m_err, and go to RESULT; core_enable SHALL be 0 from the next cycle.
REQ-026 A RUN cycle with core_done=0 and timeout counter = TIMEOUT-1 SHALL set m_data=0 and m_err=1 and go to RESULT.
REQ-027 If core_done=1 in the timeout cycle, done SHALL win (valid prediction, m_err=0).
REQ-028 core_done SHALL be ignored in LOAD and RESULT.
REQ-029 In RESULT, m_valid SHALL be 1, and m_data/m_err SHALL be held stable until m_valid=1 and m_ready=1 in the same cycle.
REQ-030 On that transfer, the next cycle SHALL be LOAD with m_valid=0, pix_cnt=0, and the timeout counter cleared.
REQ-031 m_valid SHALL be 0 in LOAD and RUN.
REQ-032 s_valid while s_ready=0 SHALL have no effect (the pixel is not consumed).

Reset
REQ-033 rst=1 at a clock edge SHALL force state LOAD, pix_cnt=0, timeout counter=0, and all buffer entries=0.
REQ-034 Reset SHALL also force outputs core_enable=0, m_valid=0, m_data=0, m_err=0, busy=0, and s_ready=1 from the first cycle after rst deasserts.
REQ-035 Reset asserted mid-LOAD, mid-RUN, or mid-RESULT SHALL abandon the job, with no result emitted.

Verification
REQ-036 Stream 64 pixels of value 1 with s_valid held high; core_done pulses 20 cycles later with core_value=7 -> core_enable rises the cycle after the 64th accept, then m_valid=1, m_data=7, m_err=0.
REQ-037 Hold m_ready=0 for 10 cycles in RESULT -> m_valid and m_data=7 stay stable; s_ready stays 0; transfer occurs on the first m_ready=1 cycle; LOAD follows.
REQ-038 Never assert core_done -> after TIMEOUT cycles in RUN, m_valid=1, m_err=1, m_data=0.
REQ-039 Pulse core_done=1 exactly in cycle TIMEOUT-1 with core_value=3 -> m_err=0, m_data=3.
REQ-040 Assert rst after 30 pixels; then stream 64 pixels i=0..63 -> img_flat pixel i equals i for all i, with no stale data; s_valid gaps (1 cycle on/1 cycle off) give the same result.
REQ-041 Pulse core_done while in LOAD -> no state change and no m_valid.
